// File: rtl/traffic_fsm.sv
// traffic_fsm -- main/side road intersection controller with pedestrian walk.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-low reset
//   tick         one-cycle timing enable from the prescaler
//   sensor_sync  side-road vehicle present (synchronized)
//   wr_sync      pedestrian walk request (synchronized)
//   prog_sync    restart request (synchronized), forces MG
//   main_light   main-road lamps {R,Y,G}, registered
//   side_light   side-road lamps {R,Y,G}, registered
//   walk_light   pedestrian walk lamp, registered
//   state        current state code, registered
//
// state | meaning
// ------+---------------------------------------------
// MG  0 | main green, side red
// MY  1 | main yellow, side red
// WK  2 | all red, pedestrian walk
// SG  3 | main red, side green (one optional extension)
// SY  4 | main red, side yellow
module traffic_fsm #(
  parameter int unsigned BASE = 6,
  parameter int unsigned EXT  = 3,
  parameter int unsigned YEL  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       sensor_sync,
  input  logic       wr_sync,
  input  logic       prog_sync,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk_light,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_MG = 3'd0,
    S_MY = 3'd1,
    S_WK = 3'd2,
    S_SG = 3'd3,
    S_SY = 3'd4
  } state_e;

  localparam logic [3:0] BASE_LD = 4'(BASE - 1);
  localparam logic [3:0] EXT_LD  = 4'(EXT - 1);
  localparam logic [3:0] YEL_LD  = 4'(YEL - 1);

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  state_e     state_q, state_d;
  logic [3:0] timer_q, timer_d;
  logic       walk_pending_q, walk_pending_d;
  logic       ext_used_q, ext_used_d;
  logic [2:0] main_q, main_d;
  logic [2:0] side_q, side_d;
  logic       walk_q, walk_d;
  logic       enter_wk;
  logic       expire;

  assign expire = tick && (timer_q == 4'd0);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    ext_used_d = ext_used_q;
    enter_wk   = 1'b0;

    if (prog_sync) begin
      state_d    = S_MG;
      timer_d    = BASE_LD;
      ext_used_d = 1'b0;
    end else begin
      case (state_q)
        S_MG, S_MY, S_WK, S_SG, S_SY: begin
          if (tick && (timer_q != 4'd0)) begin
            timer_d = timer_q - 4'd1;
          end else if (expire) begin
            case (state_q)
              S_MG: begin
                if (sensor_sync || walk_pending_q) begin
                  state_d = S_MY;
                  timer_d = YEL_LD;
                end else begin
                  timer_d = BASE_LD;
                end
              end
              S_MY: begin
                if (walk_pending_q) begin
                  state_d  = S_WK;
                  timer_d  = EXT_LD;
                  enter_wk = 1'b1;
                end else begin
                  state_d    = S_SG;
                  timer_d    = BASE_LD;
                  ext_used_d = 1'b0;
                end
              end
              S_WK: begin
                state_d    = S_SG;
                timer_d    = BASE_LD;
                ext_used_d = 1'b0;
              end
              S_SG: begin
                // A waiting side-road vehicle buys one extension per visit.
                if (sensor_sync && !ext_used_q) begin
                  timer_d    = EXT_LD;
                  ext_used_d = 1'b1;
                end else begin
                  state_d = S_SY;
                  timer_d = YEL_LD;
                end
              end
              default: begin
                state_d = S_MG;
                timer_d = BASE_LD;
              end
            endcase
          end
        end
        default: begin
          state_d = S_MG;
          timer_d = BASE_LD;
        end
      endcase
    end

    // A request arriving on the WK entry cycle survives and is served again.
    walk_pending_d = wr_sync | (walk_pending_q & ~enter_wk);
  end

  // Lamps decode from the next state so they change on the same edge.
  always_comb begin
    main_d = L_RED;
    side_d = L_RED;
    walk_d = 1'b0;
    case (state_d)
      S_MG:    main_d = L_GRN;
      S_MY:    main_d = L_YEL;
      S_WK:    walk_d = 1'b1;
      S_SG:    side_d = L_GRN;
      S_SY:    side_d = L_YEL;
      default: main_d = L_GRN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= S_MG;
      timer_q        <= BASE_LD;
      walk_pending_q <= 1'b0;
      ext_used_q     <= 1'b0;
      main_q         <= L_GRN;
      side_q         <= L_RED;
      walk_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      walk_pending_q <= walk_pending_d;
      ext_used_q     <= ext_used_d;
      main_q         <= main_d;
      side_q         <= side_d;
      walk_q         <= walk_d;
    end
  end

  assign main_light = main_q;
  assign side_light = side_q;
  assign walk_light = walk_q;
  assign state      = state_q;

endmodule

// File: tb/tb_traffic_fsm.sv
module tb_traffic_fsm;

  localparam int BASE = 6;
  localparam int EXT  = 3;
  localparam int YEL  = 2;

  logic       clock;
  logic       reset;
  logic       tick;
  logic       sensor_sync;
  logic       wr_sync;
  logic       prog_sync;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk_light;
  logic [2:0] state;

  traffic_fsm #(.BASE(BASE), .EXT(EXT), .YEL(YEL)) dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .sensor_sync (sensor_sync),
    .wr_sync     (wr_sync),
    .prog_sync   (prog_sync),
    .main_light  (main_light),
    .side_light  (side_light),
    .walk_light  (walk_light),
    .state       (state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int compared   = 0;
  int mismatched = 0;

  // Reference: phase index plus number of tick pulses still owed in it.
  int m_st;
  int m_left;
  bit m_wp;
  bit m_ext;

  logic [2:0] exp_main [5];
  logic [2:0] exp_side [5];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit rst, input bit tk, input bit sn, input bit wr, input bit pg);
    bit served;
    served = 1'b0;
    if (!rst) begin
      m_st = 0; m_left = BASE; m_wp = 1'b0; m_ext = 1'b0;
    end else begin
      if (pg) begin
        m_st = 0; m_left = BASE; m_ext = 1'b0;
      end else if (tk) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_st == 0) begin
            if (sn || m_wp) begin m_st = 1; m_left = YEL; end
            else m_left = BASE;
          end else if (m_st == 1) begin
            if (m_wp) begin m_st = 2; m_left = EXT; served = 1'b1; end
            else begin m_st = 3; m_left = BASE; m_ext = 1'b0; end
          end else if (m_st == 2) begin
            m_st = 3; m_left = BASE; m_ext = 1'b0;
          end else if (m_st == 3) begin
            if (sn && !m_ext) begin m_left = EXT; m_ext = 1'b1; end
            else begin m_st = 4; m_left = YEL; end
          end else begin
            m_st = 0; m_left = BASE;
          end
        end
      end
      if (served) m_wp = 1'b0;
      if (wr) m_wp = 1'b1;
    end
  endtask

  task automatic cyc(input bit rst, input bit tk, input bit sn, input bit wr, input bit pg);
    reset = rst; tick = tk; sensor_sync = sn; wr_sync = wr; prog_sync = pg;
    @(posedge clock);
    model(rst, tk, sn, wr, pg);
    #1;
    chk("state", 8'(state), 8'(m_st));
    chk("main", 8'(main_light), 8'(exp_main[m_st]));
    chk("side", 8'(side_light), 8'(exp_side[m_st]));
    chk("walk", 8'(walk_light), 8'(m_st == 2));
    chk("timer", 8'(dut.timer_q), 8'(m_left - 1));
    chk("walk_pending", 8'(dut.walk_pending_q), 8'(m_wp));
    chk("both_nonred", 8'((main_light != 3'b100) && (side_light != 3'b100)), 8'd0);
  endtask

  initial begin
    int cnt;
    bit found;
    bit hit;
    exp_main = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
    exp_side = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010};
    m_st = 0; m_left = BASE; m_wp = 1'b0; m_ext = 1'b0;

    // Idle: no demand keeps main green forever.
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 30; i++) cyc(1, 1, 0, 0, 0);
    chk("idle_state", 8'(state), 8'd0);

    // Constant sensor: one full cycle, side green for BASE+EXT ticks.
    cyc(0, 1, 0, 0, 0);
    cnt = 0;
    for (int i = 0; i < BASE + YEL + BASE + EXT + YEL; i++) begin
      cyc(1, 1, 1, 0, 0);
      if (side_light == 3'b001) cnt++;
    end
    chk("side_green_ticks", 8'(cnt), 8'(BASE + EXT));
    chk("back_to_mg", 8'(state), 8'd0);

    // Walk request pulse in MG.
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 0);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      cyc(1, 1, 0, 0, 0);
      if (walk_light) cnt++;
    end
    chk("walk_ticks", 8'(cnt), 8'(EXT));

    // Request landing on the MY->WK edge is re-armed.
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      hit = (m_st == 1) && (m_left == 1);
      cyc(1, 1, 0, hit, 0);
      if (hit) found = 1'b1;
    end
    chk("my_wk_reached", 8'(found), 8'd1);
    chk("rearm_state", 8'(state), 8'd2);
    chk("rearm_pending", 8'(dut.walk_pending_q), 8'd1);
    for (int i = 0; i < 30; i++) cyc(1, 1, 0, 0, 0);

    // Restart in SG at timer 2 with tick held low, then freeze.
    cyc(0, 1, 0, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_st == 3 && m_left == 3) found = 1'b1;
      else cyc(1, 1, 1, 0, 0);
    end
    chk("sg_t2_reached", 8'(found), 8'd1);
    chk("sg_t2_timer", 8'(dut.timer_q), 8'd2);
    cyc(1, 0, 1, 0, 1);
    chk("prog_state", 8'(state), 8'd0);
    chk("prog_timer", 8'(dut.timer_q), 8'(BASE - 1));
    chk("prog_main", 8'(main_light), 8'b001);
    for (int i = 0; i < 10; i++) cyc(1, 0, 1, 1, 0);
    chk("freeze_state", 8'(state), 8'd0);

    // Reset during WK.
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc(1, 1, 0, 0, 0);
      if (m_st == 2) found = 1'b1;
    end
    chk("wk_reached", 8'(found), 8'd1);
    cyc(0, 1, 1, 1, 1);
    chk("rst_walk", 8'(walk_light), 8'd0);
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_side", 8'(side_light), 8'b100);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(99) != 0,
          $urandom_range(1),
          $urandom_range(2) != 0,
          $urandom_range(14) == 0,
          $urandom_range(60) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
